// File: rtl/tetris_frame_scanner.sv
// Double-buffered 8x8 LED matrix row scanner: a producer fills a shadow frame and the scanner
// swaps it into the displayed frame only at frame boundaries, with one blank slot per row.
module tetris_frame_scanner #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rstBtn,
  input  logic [63:0] frameIn,
  input  logic        frameValid,
  output logic        frameReady,
  output logic [7:0]  rowSel,
  output logic [7:0]  colOut,
  output logic [3:0]  fullRows,
  output logic        frameSwap
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [15:0] DwellMax = 16'(DIV - 1);

  state_e      state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] active_q, active_d;
  logic        shadow_full_q, shadow_full_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] dwell_q, dwell_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_out_q, col_out_d;
  logic [3:0]  full_rows_q, full_rows_d;
  logic        frame_swap_q, frame_swap_d;
  logic        accept;
  logic        swap;

  function automatic logic [3:0] count_full(input logic [63:0] frame);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int r = 0; r < 8; r++) begin
      if (frame[8*r +: 8] == 8'hFF) begin
        cnt = cnt + 4'd1;
      end
    end
    return cnt;
  endfunction

  // Accept and swap are exclusive: accept needs the shadow empty, swap needs it full.
  assign accept = frameValid && !shadow_full_q;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    shadow_full_d = shadow_full_q;
    row_d         = row_q;
    dwell_d       = dwell_q;
    full_rows_d   = full_rows_q;
    frame_swap_d  = 1'b0;
    swap          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (shadow_full_q) begin
          swap    = 1'b1;
          state_d = StScan;
          row_d   = 3'd0;
          dwell_d = 16'd0;
        end
      end
      StScan: begin
        if (dwell_q == DwellMax) begin
          dwell_d = 16'd0;
          row_d   = row_q + 3'd1;
          if (row_q == 3'd7 && shadow_full_q) begin
            swap = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      shadow_d      = frameIn;
      shadow_full_d = 1'b1;
    end

    if (swap) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
      full_rows_d   = count_full(shadow_q);
      frame_swap_d  = 1'b1;
    end

    // Outputs are computed from next-state so they line up with the registered dwell counter.
    row_sel_d = 8'd0;
    col_out_d = 8'd0;
    if (state_d == StScan && dwell_d != 16'd0) begin
      row_sel_d = 8'd1 << row_d;
      col_out_d = active_d[{row_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      state_q       <= StIdle;
      shadow_q      <= 64'd0;
      active_q      <= 64'd0;
      shadow_full_q <= 1'b0;
      row_q         <= 3'd0;
      dwell_q       <= 16'd0;
      row_sel_q     <= 8'd0;
      col_out_q     <= 8'd0;
      full_rows_q   <= 4'd0;
      frame_swap_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      row_sel_q     <= row_sel_d;
      col_out_q     <= col_out_d;
      full_rows_q   <= full_rows_d;
      frame_swap_q  <= frame_swap_d;
    end
  end

  assign frameReady = !shadow_full_q;
  assign rowSel     = row_sel_q;
  assign colOut     = col_out_q;
  assign fullRows   = full_rows_q;
  assign frameSwap  = frame_swap_q;

endmodule

// File: tb/tb_tetris_frame_scanner.sv
// Self-checking bench for tetris_frame_scanner with DIV=4 (32-cycle frame period).
module tb_tetris_frame_scanner;

  localparam int unsigned Div = 4;

  logic        clk = 1'b0;
  logic        rstBtn = 1'b1;
  logic [63:0] frameIn = 64'd0;
  logic        frameValid = 1'b0;
  logic        frameReady;
  logic [7:0]  rowSel;
  logic [7:0]  colOut;
  logic [3:0]  fullRows;
  logic        frameSwap;

  always #5 clk = ~clk;

  tetris_frame_scanner #(.DIV(Div)) dut (
    .clk        (clk),
    .rstBtn     (rstBtn),
    .frameIn    (frameIn),
    .frameValid (frameValid),
    .frameReady (frameReady),
    .rowSel     (rowSel),
    .colOut     (colOut),
    .fullRows   (fullRows),
    .frameSwap  (frameSwap)
  );

  typedef struct packed {
    logic [63:0] frame;
    logic [3:0]  full_rows;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] cur_full = 4'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, 64'({rowSel, colOut, frameReady, fullRows, frameSwap}),
        64'({8'h00, 8'h00, 1'b1, 4'h0, 1'b0}));
  endtask

  // k counts cycles since the swap cycle: row k/4, dwell k%4, dwell 0 blank.
  task automatic chk_display(input string name, input logic [63:0] frame, input int k);
    int         row;
    int         dwell;
    logic [7:0] exp_sel;
    logic [7:0] exp_col;
    row   = (k / 4) % 8;
    dwell = k % 4;
    exp_sel = 8'd0;
    exp_col = 8'd0;
    if (dwell != 0) begin
      exp_sel = 8'd1 << row;
      exp_col = frame[8*row +: 8];
    end
    chk(name, 64'({rowSel, colOut}), 64'({exp_sel, exp_col}));
  endtask

  task automatic load(input vec_t v);
    chk("ready before load", 64'(frameReady), 64'd1);
    frameIn    = v.frame;
    frameValid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    frameValid = 1'b0;
    chk("ready after load", 64'(frameReady), 64'd0);
  endtask

  task automatic wait_swap(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frameSwap) begin
        found = 1'b1;
        break;
      end
      chk({name, " fullRows held"}, 64'(fullRows), 64'(cur_full));
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no frameSwap within 100 cycles got 0 expected 1", name);
    end
  endtask

  task automatic pop_and_check(input string name, output vec_t e);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got swap expected none", name);
      e = '0;
    end else begin
      e = sb.pop_front();
      chk({name, " fullRows"}, 64'(fullRows), 64'(e.full_rows));
      cur_full = e.full_rows;
    end
  endtask

  initial begin
    vec_t e;
    bit   found;

    vecs[0] = '{frame: 64'h00000000_000000FF, full_rows: 4'd1};
    vecs[1] = '{frame: 64'hFFFFFFFF_FFFFFFFF, full_rows: 4'd8};
    vecs[2] = '{frame: 64'h00000000_00000000, full_rows: 4'd0};
    vecs[3] = '{frame: 64'hFF00FF00_FF00FF00, full_rows: 4'd4};
    vecs[4] = '{frame: 64'h7FFFFFFF_FFFFFFFE, full_rows: 4'd6};
    vecs[5] = '{frame: 64'h01234567_89ABCDEF, full_rows: 4'd0};

    // Asynchronous reset with no clock edge in between.
    #1 rstBtn = 1'b0;
    #1 chk_idle("async reset");
    #21 rstBtn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk_idle("idle no frames");
    end

    // Table of frames: each loaded, swapped, and one full frame period plus wrap checked.
    for (int i = 0; i < 6; i++) begin
      load(vecs[i]);
      wait_swap("vector swap", found);
      pop_and_check("vector", e);
      chk_display("vector k0", e.frame, 0);
      for (int k = 1; k < 34; k++) begin
        @(negedge clk);
        chk_display("vector scan", e.frame, k);
        chk("vector no extra swap", 64'(frameSwap), 64'd0);
      end
    end

    // Frame A accepted, B held valid until shadow drains at the wrap.
    frameIn    = 64'hFFFF0000_0000FFFF;
    frameValid = 1'b1;
    sb.push_back('{frame: 64'hFFFF0000_0000FFFF, full_rows: 4'd4});
    @(negedge clk);
    frameIn = 64'h000000FF_FF0000FF;
    wait_swap("hold A", found);
    chk("ready at A swap", 64'(frameReady), 64'd1);
    pop_and_check("frame A", e);
    chk_display("frame A k0", e.frame, 0);
    sb.push_back('{frame: 64'h000000FF_FF0000FF, full_rows: 4'd3});
    @(negedge clk);
    chk("B accepted", 64'(frameReady), 64'd0);
    chk_display("frame A k1", e.frame, 1);
    frameValid = 1'b0;
    wait_swap("B swap", found);
    pop_and_check("frame B", e);
    for (int k = 1; k < 34; k++) begin
      @(negedge clk);
      chk_display("frame B scan", e.frame, k);
    end

    // Reset during row 5 with the shadow full.
    load('{frame: 64'h12345678_FFFFFFFF, full_rows: 4'd4});
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rowSel == 8'h20) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached row 5", 64'(found), 64'd1);
    chk("shadow full before reset", 64'(frameReady), 64'd0);
    #2 rstBtn = 1'b0;
    #1 chk_idle("reset mid-scan");
    sb.delete();
    cur_full = 4'd0;
    @(negedge clk);
    rstBtn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk_idle("idle after reset");
    end

    // Behaves like power-up: swap exactly one cycle after the transfer.
    load('{frame: 64'h00000000_000000FF, full_rows: 4'd1});
    @(negedge clk);
    chk("swap after reset", 64'(frameSwap), 64'd1);
    pop_and_check("post-reset frame", e);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk_display("post-reset scan", e.frame, k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tetris_frame_scanner.md
TETRIS_FRAME_SCANNER -- requirements
Module: tetris_frame_scanner

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles per row dwell, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on rising edge.
REQ-003 SHALL have port rstBtn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port frameIn, input, 64, board bitmap; row r = frameIn[8r+7:8r], column c = bit 8r+c.
REQ-005 SHALL have port frameValid, input, 1, producer asserts when frameIn holds a complete frame.
REQ-006 SHALL have port frameReady, output, 1, high when the shadow buffer can accept a frame.
REQ-007 SHALL have port rowSel, output, 8, one-hot active-high row drive; all-zero when blanked or idle.
REQ-008 SHALL have port colOut, output, 8, column data for the selected row; 0 when rowSel is 0.
REQ-009 SHALL have port fullRows, output, 4, count of rows equal to 8'hFF in the displayed frame (0..8).
REQ-010 SHALL have port frameSwap, output, 1, one-cycle pulse when a new frame becomes displayed.

Function
REQ-011 SHALL hold two 64-bit buffers: shadow (written by producer) and active (displayed), plus flag shadowFull.
REQ-012 SHALL complete a transfer on any rising edge with frameValid=1 and frameReady=1: shadow <= frameIn, shadowFull <= 1.
REQ-013 SHALL drive frameReady = !shadowFull, combinationally from the registered flag; frameIn ignored when frameReady=0.
REQ-014 SHALL implement states IDLE and SCAN; IDLE until the first frame is loaded, then SCAN forever until reset.
REQ-015 In IDLE with shadowFull=1, SHALL on next edge copy shadow to active, clear shadowFull, pulse frameSwap, enter SCAN at row 0, dwell count 0.
REQ-016 In SCAN, SHALL keep row index (3 bits) and dwell counter (0..DIV-1); counter increments every cycle, wraps to 0 and advances row at DIV-1.
REQ-017 SHALL blank on dwell count 0 (rowSel=0, colOut=0) and drive rowSel=1<<row, colOut=active row bits for counts 1..DIV-1.
REQ-018 Row 7 -> row 0 wrap is the frame boundary; only there, if shadowFull=1, SHALL copy shadow to active, clear shadowFull, pulse frameSwap in that same cycle.
REQ-019 Simultaneous transfer and swap at the boundary: swap takes the old shadow; new frameIn is not accepted that cycle since frameReady=0 beforehand.
REQ-020 With shadowFull=0 at the boundary, SHALL redisplay the same active frame, no frameSwap.
REQ-021 SHALL update fullRows registered, in the same cycle active is loaded, from the value being loaded; unchanged otherwise.
REQ-022 rowSel and colOut SHALL be registered outputs, lagging the dwell counter by at most one cycle consistently across all rows.

Reset
REQ-023 On rstBtn=0 SHALL immediately force: state IDLE, shadowFull=0, frameReady=1, rowSel=0, colOut=0, fullRows=0, frameSwap=0, buffers 0, counters 0.
REQ-024 Reset mid-scan or mid-transfer SHALL discard both buffers; after release, behaviour identical to power-up.
REQ-025 SHALL require no clock edge to reach reset values; normal operation on the first rising edge after rstBtn returns to 1.

Verification (DIV=4)
REQ-026 Reset only, no frames, 50 cycles -> rowSel=0, colOut=0, frameReady=1, fullRows=0 throughout.
REQ-027 Load frameIn=64'h00000000_000000FF, one valid cycle -> frameSwap pulse, fullRows=1, row 0 shows colOut=8'hFF for 3 of 4 cycles, rows 1..7 show 0, one blank cycle per row, frame period 32 cycles.
REQ-028 While scanning, send frame A then hold frameValid with frame B -> A accepted, frameReady=0 until next row 7->0 wrap, A displayed at wrap, B accepted the cycle after.
REQ-029 Load 64'hFFFFFFFF_FFFFFFFF -> fullRows=8; then 64'h0 -> fullRows=0 exactly at the next frameSwap, never earlier.
REQ-030 Assert rstBtn=0 during row 5 with shadow full -> all outputs zero without waiting for clk, frameReady=1; after release no display until a new frame is loaded.
